qupls_rc_port_sched: RTL and testbench

- Sequences the shared Rc register-file read ports for one decoded group of up to WIDTH instructions.
- Sits between the Rc decode stage and rename/queue.
- Accepts per-lane Rc architectural register numbers and zero flags, then issues reads, up to NPORTS per cycle, oldest lane first.
- Collects the returned data and presents the complete Rc operand set with a valid/ready handshake.

---
 rtl/qupls_rc_port_sched.sv | 162 ++++++++++++++++
 tb/tb_qupls_rc_port_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qupls_rc_port_sched.sv
// Rc register-file read-port sequencer: issues up to NPORTS reads per cycle, oldest lane first,
// and presents the complete per-lane Rc operand set. Define QUPLS_RC_DEDUP_EN to share ports between equal registers.
module qupls_rc_port_sched #(
   parameter int WIDTH  = 4,
   parameter int NPORTS = 2,
   parameter int DW     = 64,
   parameter int AW     = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     lane_v,
   input  logic [WIDTH*AW-1:0]  lane_rc,
   input  logic [WIDTH-1:0]     lane_rcz,
   output logic [NPORTS-1:0]    rf_rd_en,
   output logic [NPORTS*AW-1:0] rf_rd_reg,
   input  logic [NPORTS*DW-1:0] rf_rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH*DW-1:0]  out_rc_val,
   output logic [7:0]           busy_cycles
);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;

   state_t                       state_r, state_s;
   logic [WIDTH-1:0]             pending_r, pending_s, need_s, issue_s, taken_s;
   logic [WIDTH*AW-1:0]          rc_r;
   logic [NPORTS-1:0][WIDTH-1:0] tag_r, tag_s, sel_tag_s;
   logic [NPORTS-1:0][AW-1:0]    sel_reg_s, hold_reg_r;
   logic [NPORTS-1:0]            sel_en_s;
   logic                         grab_s, match_s, accept_s;
   logic                         in_ready_r, out_valid_r;
   logic [7:0]                   busy_r;
   logic [WIDTH*DW-1:0]          val_r;

   assign need_s      = lane_v & ~lane_rcz;
   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign out_rc_val  = val_r;
   assign busy_cycles = busy_r;
   assign rf_rd_en    = sel_en_s;

   // Port selection: walk lanes oldest first, handing each pending lane the next free port.
   always_comb begin
      sel_en_s  = '0;
      sel_reg_s = '0;
      sel_tag_s = '0;
      taken_s   = '0;
      grab_s    = 1'b0;
      match_s   = 1'b0;
      issue_s   = (state_r == READ) ? pending_r : '0;
      for (int i = 0; i < WIDTH; i++) begin
`ifdef QUPLS_RC_DEDUP_EN
         for (int k = 0; k < NPORTS; k++) begin
            match_s         = issue_s[i] && sel_en_s[k] && (sel_reg_s[k] == rc_r[i*AW +: AW]);
            sel_tag_s[k][i] = sel_tag_s[k][i] | match_s;
            taken_s[i]      = taken_s[i] | match_s;
         end
`endif
         for (int k = 0; k < NPORTS; k++) begin
            grab_s          = issue_s[i] && !taken_s[i] && !sel_en_s[k];
            sel_en_s[k]     = sel_en_s[k] | grab_s;
            sel_reg_s[k]    = grab_s ? rc_r[i*AW +: AW] : sel_reg_s[k];
            sel_tag_s[k][i] = sel_tag_s[k][i] | grab_s;
            taken_s[i]      = taken_s[i] | grab_s;
         end
      end
   end

   // Read-port register numbers; idle ports keep their last value.
   always_comb begin
      rf_rd_reg = '0;
      for (int k = 0; k < NPORTS; k++) begin
         rf_rd_reg[k*AW +: AW] = sel_en_s[k] ? sel_reg_s[k] : hold_reg_r[k];
      end
   end

   // Next-state, pending mask and return-tag logic; flush overrides every state.
   always_comb begin
      state_s   = state_r;
      pending_s = pending_r;
      tag_s     = '0;
      accept_s  = 1'b0;
      if (flush) begin
         state_s   = IDLE;
         pending_s = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  accept_s  = 1'b1;
                  pending_s = need_s;
                  state_s   = (need_s == '0) ? HOLD : READ;
               end else begin
                  pending_s = '0;
               end
            end
            READ: begin
               tag_s     = sel_tag_s;
               pending_s = pending_r & ~taken_s;
               state_s   = ((pending_r & ~taken_s) == '0) ? DRAIN : READ;
            end
            DRAIN:   state_s = HOLD;
            HOLD:    state_s = out_ready ? IDLE : HOLD;
            default: begin
               state_s   = IDLE;
               pending_s = '0;
            end
         endcase
      end
   end

   // Control state, handshake flags and issue bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         pending_r   <= '0;
         tag_r       <= '0;
         rc_r        <= '0;
         hold_reg_r  <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 8'd0;
      end else begin
         state_r     <= state_s;
         pending_r   <= pending_s;
         tag_r       <= tag_s;
         hold_reg_r  <= rf_rd_reg;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == HOLD);
         if (accept_s) begin
            rc_r <= lane_rc;
         end
         if (flush || accept_s) begin
            busy_r <= 8'd0;
         end else if ((state_r == READ) && (busy_r != 8'hFF)) begin
            busy_r <= busy_r + 8'd1;
         end
      end
   end

   // Operand capture: a new group starts from zero, so unread lanes stay 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_r <= '0;
      end else if (accept_s) begin
         val_r <= '0;
      end else if (!flush) begin
         for (int k = 0; k < NPORTS; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (tag_r[k][i]) begin
                  val_r[i*DW +: DW] <= rf_rd_data[k*DW +: DW];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_qupls_rc_port_sched.sv
// Directed bench for qupls_rc_port_sched (WIDTH=4, NPORTS=2) with a one-cycle-latency register-file model.
module tb_qupls_rc_port_sched;
   localparam int WIDTH  = 4;
   localparam int NPORTS = 2;
   localparam int DW     = 64;
   localparam int AW     = 9;

   logic                 clk = 1'b0;
   logic                 rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0]     lane_v, lane_rcz;
   logic [WIDTH*AW-1:0]  lane_rc;
   logic [NPORTS-1:0]    rf_rd_en;
   logic [NPORTS*AW-1:0] rf_rd_reg;
   logic [NPORTS*DW-1:0] rf_rd_data = '0;
   logic [WIDTH*DW-1:0]  out_rc_val;
   logic [7:0]           busy_cycles;
   int                   checks = 0;
   int                   errors = 0;

   always #5 clk = ~clk;

   qupls_rc_port_sched #(.WIDTH(WIDTH), .NPORTS(NPORTS), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .lane_v(lane_v), .lane_rc(lane_rc), .lane_rcz(lane_rcz),
      .rf_rd_en(rf_rd_en), .rf_rd_reg(rf_rd_reg), .rf_rd_data(rf_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rc_val(out_rc_val),
      .busy_cycles(busy_cycles)
   );

   function automatic logic [DW-1:0] rfval(input logic [AW-1:0] r);
      return {16'hA5A5, 16'(r), 16'h5A5A, 16'(r) ^ 16'hFFFF};
   endfunction

   // Register file: data for a strobe appears exactly one cycle later; idle ports return junk.
   always @(posedge clk) begin
      for (int k = 0; k < NPORTS; k++) begin
         rf_rd_data[k*DW +: DW] <= rf_rd_en[k] ? rfval(rf_rd_reg[k*AW +: AW]) : 64'hDEAD_BEEF_DEAD_BEEF;
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   // Present one group for a single cycle; returns at the negedge after the accept edge.
   task automatic present(input logic [3:0] v, input logic [3:0] z,
                          input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                          input logic [AW-1:0] r2, input logic [AW-1:0] r3);
      lane_v   = v;
      lane_rcz = z;
      lane_rc  = {r3, r2, r1, r0};
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) cyc();
      checks++;
      if ({in_ready, out_valid, rf_rd_en, busy_cycles} !== {1'b1, 1'b0, 2'b00, 8'd0}) begin
         errors++; $display("FAIL reset_ctl got %b want %b", {in_ready, out_valid, rf_rd_en, busy_cycles}, 12'b100000000000);
      end
      checks++;
      if (rf_rd_reg !== 18'd0 || out_rc_val !== '0) begin
         errors++; $display("FAIL reset_data got reg %h val %h want 0", rf_rd_reg, out_rc_val);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_four_lanes();
      present(4'b1111, 4'b0000, 9'd5, 9'd6, 9'd7, 9'd8);
      checks++;
      if (rf_rd_en !== 2'b11 || rf_rd_reg !== {9'd6, 9'd5}) begin
         errors++; $display("FAIL four_c1 got en %b reg %h want 11 %h", rf_rd_en, rf_rd_reg, {9'd6, 9'd5});
      end
      cyc();
      checks++;
      if (rf_rd_en !== 2'b11 || rf_rd_reg !== {9'd8, 9'd7}) begin
         errors++; $display("FAIL four_c2 got en %b reg %h want 11 %h", rf_rd_en, rf_rd_reg, {9'd8, 9'd7});
      end
      cyc();
      checks++;
      if (rf_rd_en !== 2'b00 || rf_rd_reg !== {9'd8, 9'd7} || out_valid !== 1'b0) begin
         errors++; $display("FAIL four_drain got en %b reg %h ov %b want 00 %h 0", rf_rd_en, rf_rd_reg, out_valid, {9'd8, 9'd7});
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy_cycles !== 8'd2) begin
         errors++; $display("FAIL four_done got ov %b ir %b busy %0d want 1 0 2", out_valid, in_ready, busy_cycles);
      end
      checks++;
      if (out_rc_val !== {rfval(9'd8), rfval(9'd7), rfval(9'd6), rfval(9'd5)}) begin
         errors++; $display("FAIL four_data got %h want %h", out_rc_val, {rfval(9'd8), rfval(9'd7), rfval(9'd6), rfval(9'd5)});
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL four_release got ir %b ov %b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_all_zero();
      present(4'b1111, 4'b1111, 9'd1, 9'd2, 9'd3, 9'd4);
      checks++;
      if (rf_rd_en !== 2'b00 || out_valid !== 1'b1 || busy_cycles !== 8'd0) begin
         errors++; $display("FAIL zero_ctl got en %b ov %b busy %0d want 00 1 0", rf_rd_en, out_valid, busy_cycles);
      end
      checks++;
      if (out_rc_val !== '0) begin
         errors++; $display("FAIL zero_data got %h want 0", out_rc_val);
      end
      release_out();
   endtask

   task automatic test_sparse();
      present(4'b0101, 4'b0000, 9'd10, 9'd33, 9'd12, 9'd44);
      checks++;
      if (rf_rd_en !== 2'b11 || rf_rd_reg !== {9'd12, 9'd10}) begin
         errors++; $display("FAIL sparse_c1 got en %b reg %h want 11 %h", rf_rd_en, rf_rd_reg, {9'd12, 9'd10});
      end
      cyc();
      checks++;
      if (rf_rd_en !== 2'b00 || out_valid !== 1'b0) begin
         errors++; $display("FAIL sparse_drain got en %b ov %b want 00 0", rf_rd_en, out_valid);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || busy_cycles !== 8'd1 ||
          out_rc_val !== {64'd0, rfval(9'd12), 64'd0, rfval(9'd10)}) begin
         errors++; $display("FAIL sparse_done got ov %b busy %0d val %h want 1 1 %h", out_valid, busy_cycles,
                            out_rc_val, {64'd0, rfval(9'd12), 64'd0, rfval(9'd10)});
      end
      release_out();
   endtask

   task automatic test_flush();
      present(4'b1111, 4'b0000, 9'd5, 9'd6, 9'd7, 9'd8);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || rf_rd_en !== 2'b00) begin
         errors++; $display("FAIL flush_idle got ir %b ov %b en %b want 1 0 00", in_ready, out_valid, rf_rd_en);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0 || out_rc_val[4*DW-1:2*DW] !== '0) begin
         errors++; $display("FAIL flush_stale got ov %b hi %h want 0 0", out_valid, out_rc_val[4*DW-1:2*DW]);
      end
      present(4'b0001, 4'b0000, 9'd20, 9'd0, 9'd0, 9'd0);
      checks++;
      if (rf_rd_en !== 2'b01 || rf_rd_reg !== {9'd8, 9'd20}) begin
         errors++; $display("FAIL flush_new_issue got en %b reg %h want 01 %h", rf_rd_en, rf_rd_reg, {9'd8, 9'd20});
      end
      repeat (2) cyc();
      checks++;
      if (out_valid !== 1'b1 || out_rc_val !== {64'd0, 64'd0, 64'd0, rfval(9'd20)}) begin
         errors++; $display("FAIL flush_new_done got ov %b val %h want 1 %h", out_valid, out_rc_val,
                            {64'd0, 64'd0, 64'd0, rfval(9'd20)});
      end
      release_out();
   endtask

   task automatic test_hold_stall();
      logic [WIDTH*DW-1:0] exp_val;
      exp_val = {64'd0, 64'd0, rfval(9'd31), rfval(9'd30)};
      present(4'b0011, 4'b0000, 9'd30, 9'd31, 9'd0, 9'd0);
      repeat (2) cyc();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rc_val !== exp_val) begin
            errors++; $display("FAIL hold_stall[%0d] got ov %b ir %b val %h want 1 0 %h", i, out_valid, in_ready, out_rc_val, exp_val);
         end
         cyc();
      end
      out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL hold_same_cycle got ir %b want 0", in_ready);
      end
      cyc();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL hold_release got ir %b ov %b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_dedup();
      logic [WIDTH*DW-1:0] exp_val;
      exp_val = {rfval(9'd4), rfval(9'd9), rfval(9'd9), rfval(9'd9)};
      present(4'b1111, 4'b0000, 9'd9, 9'd9, 9'd9, 9'd4);
`ifdef QUPLS_RC_DEDUP_EN
      checks++;
      if (rf_rd_en !== 2'b11 || rf_rd_reg !== {9'd4, 9'd9}) begin
         errors++; $display("FAIL dedup_c1 got en %b reg %h want 11 %h", rf_rd_en, rf_rd_reg, {9'd4, 9'd9});
      end
      cyc();
      checks++;
      if (rf_rd_en !== 2'b00 || out_valid !== 1'b0) begin
         errors++; $display("FAIL dedup_drain got en %b ov %b want 00 0", rf_rd_en, out_valid);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || busy_cycles !== 8'd1 || out_rc_val !== exp_val) begin
         errors++; $display("FAIL dedup_done got ov %b busy %0d val %h want 1 1 %h", out_valid, busy_cycles, out_rc_val, exp_val);
      end
`else
      checks++;
      if (rf_rd_en !== 2'b11 || rf_rd_reg !== {9'd9, 9'd9}) begin
         errors++; $display("FAIL dup_c1 got en %b reg %h want 11 %h", rf_rd_en, rf_rd_reg, {9'd9, 9'd9});
      end
      cyc();
      checks++;
      if (rf_rd_en !== 2'b11 || rf_rd_reg !== {9'd4, 9'd9}) begin
         errors++; $display("FAIL dup_c2 got en %b reg %h want 11 %h", rf_rd_en, rf_rd_reg, {9'd4, 9'd9});
      end
      repeat (2) cyc();
      checks++;
      if (out_valid !== 1'b1 || busy_cycles !== 8'd2 || out_rc_val !== exp_val) begin
         errors++; $display("FAIL dup_done got ov %b busy %0d val %h want 1 2 %h", out_valid, busy_cycles, out_rc_val, exp_val);
      end
`endif
      release_out();
   endtask

   task automatic test_reset_mid_read();
      present(4'b1111, 4'b0000, 9'd5, 9'd6, 9'd7, 9'd8);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, rf_rd_en, busy_cycles} !== {1'b1, 1'b0, 2'b00, 8'd0} || rf_rd_reg !== 18'd0) begin
         errors++; $display("FAIL rst_mid got ctl %b reg %h want 100000000000 0", {in_ready, out_valid, rf_rd_en, busy_cycles}, rf_rd_reg);
      end
      cyc();
      rst_n = 1'b1;
      repeat (2) cyc();
      checks++;
      if (out_rc_val !== '0 || rf_rd_en !== 2'b00 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_after got val %h en %b ir %b want 0 00 1", out_rc_val, rf_rd_en, in_ready);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      lane_v    = 4'b0000;
      lane_rcz  = 4'b0000;
      lane_rc   = '0;
      test_reset();
      test_four_lanes();
      test_all_zero();
      test_sparse();
      test_flush();
      test_hold_stall();
      test_dedup();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
